// File: rtl/sync_frame_capture_pkg.sv
// Shared types and helpers for the serial frame capture block.
package sync_frame_capture_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_e;

    // Bits needed to count 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/bit_align_dly.sv
// Short shift chain that lines the serial stream up with the detector's pulse.
module bit_align_dly #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_chain
        logic [DEPTH-1:0] chain_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                chain_q <= '0;
            end else begin
                chain_q[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    chain_q[i] <= chain_q[i-1];
                end
            end
        end

        assign q = chain_q[DEPTH-1];
    end

endmodule

// File: rtl/sync_frame_capture.sv
// Captures the payload that follows each detected sync word and offers it
// as a parallel word on a single-entry valid/ready register.
module sync_frame_capture
    import sync_frame_capture_pkg::*;
#(
    parameter int PAYLOAD_W = 8,
    parameter int ALIGN_DLY = 1,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 sync_det,
    output logic [PAYLOAD_W-1:0] frame_data,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 overrun,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 busy
);

    localparam int BCNT_W = clog2(PAYLOAD_W);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(PAYLOAD_W - 1);

    state_e                state_q, state_d;
    logic [BCNT_W-1:0]     cnt_q, cnt_d;
    logic [PAYLOAD_W-1:0]  sreg_q, sreg_d;
    logic [PAYLOAD_W-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic [CNT_W-1:0]      fcnt_q, fcnt_d;
    logic                  tap;
    logic                  complete;
    logic [PAYLOAD_W-1:0]  word;

    bit_align_dly #(
        .DEPTH(ALIGN_DLY)
    ) u_align (
        .clk(clk),
        .rst(rst),
        .d  (bit_in),
        .q  (tap)
    );

    assign word = {sreg_q[PAYLOAD_W-2:0], tap};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            sreg_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            fcnt_q    <= fcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        fcnt_d    = fcnt_q;
        complete  = 1'b0;

        // Sync pulses are ignored while capturing, since payload bits may alias the sync word.
        case (state_q)
            HUNT: begin
                if (sync_det) begin
                    sreg_d  = word;
                    cnt_d   = BCNT_W'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                sreg_d = word;
                if (cnt_q == LAST_BIT) begin
                    cnt_d    = '0;
                    state_d  = HUNT;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        // A full register only takes the new word if it is being drained on this same edge.
        if (complete) begin
            if (!valid_q || frame_ready) begin
                data_d  = word;
                valid_d = 1'b1;
                fcnt_d  = fcnt_q + 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end
    end

    assign frame_data  = data_q;
    assign frame_valid = valid_q;
    assign overrun     = overrun_q;
    assign frame_cnt   = fcnt_q;
    assign busy        = (state_q == CAPTURE);

endmodule

// File: tb/tb_sync_frame_capture.sv
// Directed bench for sync_frame_capture driven by a model of the 1101 detector.
module tb_sync_frame_capture;

    logic       clk;
    logic       rst;
    logic       bitIn;
    logic       syncDet;
    logic [7:0] frameData;
    logic       frameValid;
    logic       frameReady;
    logic       overrun;
    logic [7:0] frameCnt;
    logic       busy;

    int checkCount;
    int errorCount;
    int overrunPulses;
    int validCycles;

    logic [3:0] detHist;
    logic       detFinal;

    sync_frame_capture #(
        .PAYLOAD_W(8),
        .ALIGN_DLY(1),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bitIn),
        .sync_det   (syncDet),
        .frame_data (frameData),
        .frame_valid(frameValid),
        .frame_ready(frameReady),
        .overrun    (overrun),
        .frame_cnt  (frameCnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overlapping 1101 detector: registered final state, then a registered detected pulse.
    always @(posedge clk) begin
        if (rst) begin
            detHist  <= 4'b0000;
            detFinal <= 1'b0;
            syncDet  <= 1'b0;
        end else begin
            detHist  <= {detHist[2:0], bitIn};
            detFinal <= ({detHist[2:0], bitIn} == 4'b1101);
            syncDet  <= detFinal;
        end
    end

    always @(posedge clk) begin
        if (overrun === 1'b1) overrunPulses++;
        if (frameValid === 1'b1) validCycles++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Drive one bit at a negedge and return at the following negedge.
    task automatic sendBit(input logic b);
        bitIn = b;
        @(negedge clk);
    endtask

    task automatic sendBits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sendBit(v[i]);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        sendBit(1'b0);
        sendBit(1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        frameReady = 1'b1;
        resetDut();
        checkCount++;
        if (frameValid !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_valid: got %b expected 0", frameValid);
        end
        checkCount++;
        if (frameCnt !== 8'd0) begin
            errorCount++;
            $display("[TB] FAIL reset_cnt: got %0d expected 0", frameCnt);
        end
        checkCount++;
        if (frameData !== 8'h00) begin
            errorCount++;
            $display("[TB] FAIL reset_data: got %h expected 00", frameData);
        end
        checkCount++;
        if ({busy, overrun} !== 2'b00) begin
            errorCount++;
            $display("[TB] FAIL reset_busy_overrun: got %b expected 00", {busy, overrun});
        end
    endtask

    task automatic test_basic_frame();
        int baseValid;
        int baseOverrun;
        frameReady = 1'b1;
        resetDut();
        baseValid   = validCycles;
        baseOverrun = overrunPulses;
        sendBits(32'h0, 4);
        sendBits(32'hD, 4);
        sendBits(32'hA, 4);
        checkCount++;
        if (busy !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL basic_busy: got %b expected 1", busy);
        end
        sendBits(32'h5, 4);
        checkCount++;
        if (frameValid !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL basic_latency_early: got %b expected 0", frameValid);
        end
        sendBit(1'b0);
        checkCount++;
        if ({frameValid, frameData} !== {1'b1, 8'hA5}) begin
            errorCount++;
            $display("[TB] FAIL basic_data: got valid %b data %h expected valid 1 data a5", frameValid, frameData);
        end
        checkCount++;
        if ({busy, frameCnt} !== {1'b0, 8'd1}) begin
            errorCount++;
            $display("[TB] FAIL basic_cnt: got busy %b cnt %0d expected busy 0 cnt 1", busy, frameCnt);
        end
        sendBits(32'h0, 4);
        checkCount++;
        if (validCycles - baseValid !== 1) begin
            errorCount++;
            $display("[TB] FAIL basic_valid_pulse: got %0d cycles expected 1", validCycles - baseValid);
        end
        checkCount++;
        if (overrunPulses - baseOverrun !== 0) begin
            errorCount++;
            $display("[TB] FAIL basic_overrun: got %0d pulses expected 0", overrunPulses - baseOverrun);
        end
    endtask

    task automatic test_aliased_payload();
        frameReady = 1'b1;
        resetDut();
        sendBits(32'h0, 4);
        sendBits(32'hD, 4);
        sendBits(32'hDD, 8);
        sendBit(1'b0);
        checkCount++;
        if ({frameValid, frameData} !== {1'b1, 8'hDD}) begin
            errorCount++;
            $display("[TB] FAIL alias_data: got valid %b data %h expected valid 1 data dd", frameValid, frameData);
        end
        sendBits(32'h0, 4);
        checkCount++;
        if (frameCnt !== 8'd1) begin
            errorCount++;
            $display("[TB] FAIL alias_cnt: got %0d expected 1", frameCnt);
        end
    endtask

    task automatic test_overrun();
        int baseOverrun;
        frameReady = 1'b0;
        resetDut();
        baseOverrun = overrunPulses;
        sendBits(32'h0, 4);
        sendBits(32'hD, 4);
        sendBits(32'h3C, 8);
        sendBits(32'hD, 4);
        sendBits(32'h81, 8);
        sendBit(1'b0);
        checkCount++;
        if (overrun !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL overrun_pulse: got %b expected 1", overrun);
        end
        sendBit(1'b0);
        checkCount++;
        if (overrun !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL overrun_not_sticky: got %b expected 0", overrun);
        end
        sendBits(32'h0, 4);
        checkCount++;
        if ({frameValid, frameData, frameCnt} !== {1'b1, 8'h3C, 8'd1}) begin
            errorCount++;
            $display("[TB] FAIL overrun_hold: got valid %b data %h cnt %0d expected valid 1 data 3c cnt 1",
                     frameValid, frameData, frameCnt);
        end
        checkCount++;
        if (overrunPulses - baseOverrun !== 1) begin
            errorCount++;
            $display("[TB] FAIL overrun_count: got %0d pulses expected 1", overrunPulses - baseOverrun);
        end
    endtask

    task automatic test_back_to_back_accept();
        int baseOverrun;
        frameReady = 1'b0;
        resetDut();
        baseOverrun = overrunPulses;
        sendBits(32'h0, 4);
        sendBits(32'hD, 4);
        sendBits(32'h3C, 8);
        sendBits(32'hD, 4);
        sendBits(32'h81, 8);
        frameReady = 1'b1;
        sendBit(1'b0);
        frameReady = 1'b0;
        checkCount++;
        if ({frameValid, frameData, frameCnt} !== {1'b1, 8'h81, 8'd2}) begin
            errorCount++;
            $display("[TB] FAIL same_edge_accept: got valid %b data %h cnt %0d expected valid 1 data 81 cnt 2",
                     frameValid, frameData, frameCnt);
        end
        sendBits(32'h0, 4);
        checkCount++;
        if (overrunPulses - baseOverrun !== 0) begin
            errorCount++;
            $display("[TB] FAIL same_edge_overrun: got %0d pulses expected 0", overrunPulses - baseOverrun);
        end
    endtask

    task automatic test_mid_reset();
        int baseValid;
        frameReady = 1'b1;
        resetDut();
        sendBits(32'h0, 4);
        sendBits(32'hD, 4);
        sendBits(32'hA, 4);
        checkCount++;
        if (busy !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL midreset_busy_before: got %b expected 1", busy);
        end
        rst = 1'b1;
        sendBit(1'b0);
        rst = 1'b0;
        checkCount++;
        if ({frameValid, frameCnt, busy} !== {1'b0, 8'd0, 1'b0}) begin
            errorCount++;
            $display("[TB] FAIL midreset_state: got valid %b cnt %0d busy %b expected valid 0 cnt 0 busy 0",
                     frameValid, frameCnt, busy);
        end
        baseValid = validCycles;
        sendBits(32'hD, 4);
        sendBits(32'hF0, 8);
        sendBit(1'b0);
        checkCount++;
        if ({frameValid, frameData, frameCnt} !== {1'b1, 8'hF0, 8'd1}) begin
            errorCount++;
            $display("[TB] FAIL midreset_next: got valid %b data %h cnt %0d expected valid 1 data f0 cnt 1",
                     frameValid, frameData, frameCnt);
        end
        sendBits(32'h0, 4);
        checkCount++;
        if (validCycles - baseValid !== 1) begin
            errorCount++;
            $display("[TB] FAIL midreset_single: got %0d valid cycles expected 1", validCycles - baseValid);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] payload;
        logic [7:0] expCnt;
        frameReady = 1'b1;
        resetDut();
        for (int i = 0; i < 256; i++) begin
            payload = 8'(i * 29 + 7);
            if (payload[3:0] == 4'hD) payload[3:0] = 4'h2;
            expCnt = 8'(i + 1);
            sendBits(32'h0, 4);
            sendBits(32'hD, 4);
            sendBits({24'h0, payload}, 8);
            sendBit(1'b0);
            checkCount++;
            if ({frameValid, frameData} !== {1'b1, payload}) begin
                errorCount++;
                $display("[TB] FAIL wrap_data[%0d]: got valid %b data %h expected valid 1 data %h",
                         i, frameValid, frameData, payload);
            end
            checkCount++;
            if (frameCnt !== expCnt) begin
                errorCount++;
                $display("[TB] FAIL wrap_cnt[%0d]: got %0d expected %0d", i, frameCnt, expCnt);
            end
        end
    endtask

    // Scenarios run in order; each begins from its own reset.
    initial begin
        checkCount    = 0;
        errorCount    = 0;
        overrunPulses = 0;
        validCycles   = 0;
        rst           = 1'b1;
        bitIn         = 1'b0;
        frameReady    = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_aliased_payload();
        test_overrun();
        test_back_to_back_accept();
        test_mid_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
